// File: rtl/gainv_dac_tx_if.sv
// Parallel word-load side and serial DAC pins of the gain-voltage DAC transmitter.
interface gainv_dac_tx_if;
    logic [11:0] Din;
    logic        Load;
    logic        SCLK;
    logic        SDI;
    logic        CSn;
    logic        Busy;
    logic        Done;

    modport master (output Din, output Load,
                    input  SCLK, input SDI, input CSn, input Busy, input Done);
    modport slave  (input  Din, input Load,
                    output SCLK, output SDI, output CSn, output Busy, output Done);
endinterface

// File: rtl/gainv_dac_tx.sv
// Serialises {CMD, 12-bit gain word} MSB first to an SPI-style DAC, with a
// one-deep latest-wins pending register for words that arrive during a frame.
module gainv_dac_tx #(
    parameter int unsigned CLKDIV = 2,
    parameter logic [3:0]  CMD    = 4'b0000,
    parameter int unsigned GAP    = 2
) (
    input  logic          Clock,
    input  logic          Resetn,
    gainv_dac_tx_if.slave bus
);

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic        half_low;
    logic [14:0] shreg;       // frame bits below the one currently on SDI
    logic [11:0] pend_word;
    logic        pend_vld;
    logic        sclk_q;
    logic        sdi_q;
    logic        csn_q;
    logic        busy_q;
    logic        done_q;

    logic        div_last;
    logic        start_now;
    logic [11:0] start_word;

    assign div_last = (div_cnt == DIV_LAST);

    // A fresh Load at the end of the gap beats an older pending word.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        start_now  = 1'b0;
        start_word = bus.Din;
        case (state)
            S_IDLE: start_now = bus.Load;
            S_GAP: begin
                if (div_cnt == GAP_LAST) begin
                    start_now  = bus.Load | pend_vld;
                    start_word = bus.Load ? bus.Din : pend_word;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            half_low  <= 1'b0;
            shreg     <= '0;
            pend_word <= '0;
            pend_vld  <= 1'b0;
            sclk_q    <= 1'b1;
            sdi_q     <= 1'b0;
            csn_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (busy_q && bus.Load && !start_now) begin
                pend_word <= bus.Din;
                pend_vld  <= 1'b1;
            end

            if (start_now) begin
                state    <= S_SETUP;
                shreg    <= {CMD[2:0], start_word};
                sdi_q    <= CMD[3];
                csn_q    <= 1'b0;
                sclk_q   <= 1'b1;
                busy_q   <= 1'b1;
                div_cnt  <= '0;
                bit_cnt  <= 5'd15;
                half_low <= 1'b0;
                pend_vld <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_SETUP: begin
                        if (div_last) begin
                            state   <= S_SHIFT;
                            div_cnt <= '0;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                    S_SHIFT: begin
                        if (!div_last) begin
                            div_cnt <= div_cnt + 8'd1;
                        end else begin
                            div_cnt <= '0;
                            if (!half_low) begin
                                sclk_q   <= 1'b0;
                                half_low <= 1'b1;
                            end else begin
                                // Bit ends on the SCLK rise; the DAC already sampled on the fall.
                                sclk_q   <= 1'b1;
                                half_low <= 1'b0;
                                if (bit_cnt == 5'd0) begin
                                    state <= S_HOLD;
                                    sdi_q <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt - 5'd1;
                                    sdi_q   <= shreg[14];
                                    shreg   <= {shreg[13:0], 1'b0};
                                end
                            end
                        end
                    end
                    S_HOLD: begin
                        if (div_last) begin
                            csn_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state   <= S_GAP;
                            div_cnt <= '0;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (div_cnt == GAP_LAST) begin
                            state   <= S_IDLE;
                            busy_q  <= 1'b0;
                            div_cnt <= '0;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.SCLK = sclk_q;
    assign bus.SDI  = sdi_q;
    assign bus.CSn  = csn_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;

endmodule

// File: tb/tb_gainv_dac_tx.sv
// Directed bench for gainv_dac_tx: a DAC-side monitor decodes frames on SCLK
// falls; two instances cover CLKDIV=2/CMD=0 and CLKDIV=1/CMD=3.
module tb_gainv_dac_tx;

    logic clk;
    logic rst_n;

    gainv_dac_tx_if bus_a ();
    gainv_dac_tx_if bus_b ();

    gainv_dac_tx #(.CLKDIV(2), .CMD(4'b0000), .GAP(2)) dut_a (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus_a)
    );

    gainv_dac_tx #(.CLKDIV(1), .CMD(4'b0011), .GAP(2)) dut_b (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- DAC-side monitor (index 0 = dut_a, 1 = dut_b) ----------------
    int          fcnt[2], nbits[2], low_len[2], gap_run[2], done_cnt[2], sdi_bad[2];
    int          hi_run[2], lo_run[2], hmin[2], hmax[2], lmin[2], lmax[2];
    bit          hi_valid[2], lo_valid[2], in_frame[2];
    logic [15:0] sh[2];
    logic        prev_csn[2], prev_sclk[2];
    logic [15:0] w_log[2][16];
    int          len_log[2][16], nb_log[2][16], g_log[2][16];
    int          hmin_log[2][16], hmax_log[2][16], lmin_log[2][16], lmax_log[2][16];

    initial begin
        for (int i = 0; i < 2; i++) begin
            fcnt[i] = 0; nbits[i] = 0; low_len[i] = 0; gap_run[i] = 0;
            done_cnt[i] = 0; sdi_bad[i] = 0; in_frame[i] = 0;
            prev_csn[i] = 1'b1; prev_sclk[i] = 1'b1; sh[i] = '0;
        end
    end

    always @(negedge clk) begin
        logic [1:0] c_csn, c_sclk, c_sdi, c_done;
        c_csn  = {bus_b.CSn,  bus_a.CSn};
        c_sclk = {bus_b.SCLK, bus_a.SCLK};
        c_sdi  = {bus_b.SDI,  bus_a.SDI};
        c_done = {bus_b.Done, bus_a.Done};
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                in_frame[i] = 0;
            end else begin
                if (c_csn[i] && c_sdi[i]) sdi_bad[i]++;
                if (c_done[i]) done_cnt[i]++;
                if (prev_csn[i] && !c_csn[i]) begin
                    if (fcnt[i] < 16) g_log[i][fcnt[i]] = gap_run[i];
                    in_frame[i] = 1; sh[i] = '0; nbits[i] = 0; low_len[i] = 0;
                    hi_valid[i] = 0; lo_valid[i] = 0;
                    hmin[i] = 255; hmax[i] = 0; lmin[i] = 255; lmax[i] = 0;
                end
                if (c_csn[i]) gap_run[i]++;
                else          low_len[i]++;
                if (in_frame[i] && !c_csn[i]) begin
                    if (prev_sclk[i] && !c_sclk[i]) begin
                        sh[i] = {sh[i][14:0], c_sdi[i]};
                        nbits[i]++;
                        if (hi_valid[i]) begin
                            if (hi_run[i] < hmin[i]) hmin[i] = hi_run[i];
                            if (hi_run[i] > hmax[i]) hmax[i] = hi_run[i];
                        end
                        lo_run[i] = 1; lo_valid[i] = 1; hi_valid[i] = 0;
                    end else if (!prev_sclk[i] && c_sclk[i]) begin
                        if (lo_valid[i]) begin
                            if (lo_run[i] < lmin[i]) lmin[i] = lo_run[i];
                            if (lo_run[i] > lmax[i]) lmax[i] = lo_run[i];
                        end
                        hi_run[i] = 1; hi_valid[i] = 1; lo_valid[i] = 0;
                    end else if (c_sclk[i]) begin
                        hi_run[i]++;
                    end else begin
                        lo_run[i]++;
                    end
                end
                if (!prev_csn[i] && c_csn[i]) begin
                    if (in_frame[i] && fcnt[i] < 16) begin
                        w_log[i][fcnt[i]]    = sh[i];
                        len_log[i][fcnt[i]]  = low_len[i];
                        nb_log[i][fcnt[i]]   = nbits[i];
                        hmin_log[i][fcnt[i]] = hmin[i];
                        hmax_log[i][fcnt[i]] = hmax[i];
                        lmin_log[i][fcnt[i]] = lmin[i];
                        lmax_log[i][fcnt[i]] = lmax[i];
                        fcnt[i]++;
                    end
                    in_frame[i] = 0;
                    gap_run[i]  = 1;
                end
            end
            prev_csn[i]  = c_csn[i];
            prev_sclk[i] = c_sclk[i];
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic busy_of(input int d);
        return (d == 0) ? bus_a.Busy : bus_b.Busy;
    endfunction

    task automatic pulse_load(input int d, input logic [11:0] w);
        @(posedge clk); #1;
        if (d == 0) begin bus_a.Din = w; bus_a.Load = 1'b1; end
        else        begin bus_b.Din = w; bus_b.Load = 1'b1; end
        @(posedge clk); #1;
        // Scramble Din right after capture; the frame in flight must not see it.
        if (d == 0) begin bus_a.Load = 1'b0; bus_a.Din = ~w; end
        else        begin bus_b.Load = 1'b0; bus_b.Din = ~w; end
    endtask

    task automatic wait_idle(input int d, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_of(d) && n < 2000);
        check({tag, "_idle"}, 32'(busy_of(d)), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int n, base, base_b, d0;

        rst_n = 1'b0;
        bus_a.Din = '0; bus_a.Load = 1'b0;
        bus_b.Din = '0; bus_b.Load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", 32'(bus_a.SCLK), 1);
        check("rst_sdi",  32'(bus_a.SDI),  0);
        check("rst_csn",  32'(bus_a.CSn),  1);
        check("rst_busy", 32'(bus_a.Busy), 0);
        check("rst_done", 32'(bus_a.Done), 0);
        check("rst_csn_b", 32'(bus_b.CSn), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single frame, CLKDIV=2: 68-cycle CSn low, Busy low in cycle 71.
        base = fcnt[0]; d0 = done_cnt[0];
        pulse_load(0, 12'hA5C);
        check("t1_busy_rise", 32'(bus_a.Busy), 1);
        wait_idle(0, "t1", n);
        check("t1_busy_cycles", n, 71);
        check("t1_frames", fcnt[0] - base, 1);
        check("t1_word", 32'(w_log[0][base]), 'h0A5C);
        check("t1_csn_low", len_log[0][base], 68);
        check("t1_bits", nb_log[0][base], 16);
        check("t1_done", done_cnt[0] - d0, 1);

        // All-ones then all-zeros, with SCLK half-period widths.
        base = fcnt[0];
        pulse_load(0, 12'hFFF);
        wait_idle(0, "t2a", n);
        pulse_load(0, 12'h000);
        wait_idle(0, "t2b", n);
        check("t2_word_fff", 32'(w_log[0][base]), 'h0FFF);
        check("t2_word_000", 32'(w_log[0][base + 1]), 'h0000);
        check("t2_hi_min", hmin_log[0][base], 2);
        check("t2_hi_max", hmax_log[0][base], 2);
        check("t2_lo_min", lmin_log[0][base], 2);
        check("t2_lo_max", lmax_log[0][base], 2);
        check("t2_hi_max_000", hmax_log[0][base + 1], 2);
        check("t2_lo_min_000", lmin_log[0][base + 1], 2);

        // Two loads during a frame: the latest one wins, exactly two frames.
        base = fcnt[0]; d0 = done_cnt[0];
        pulse_load(0, 12'h111);
        repeat (10) @(posedge clk);
        pulse_load(0, 12'h222);
        repeat (20) @(posedge clk);
        pulse_load(0, 12'h333);
        wait_idle(0, "t3", n);
        repeat (5) @(posedge clk);
        check("t3_frames", fcnt[0] - base, 2);
        check("t3_word0", 32'(w_log[0][base]), 'h0111);
        check("t3_word1", 32'(w_log[0][base + 1]), 'h0333);
        check("t3_gap", g_log[0][base + 1], 2);
        check("t3_done", done_cnt[0] - d0, 2);

        // Reset during bit 7 aborts the frame; only a new Load restarts.
        base = fcnt[0]; d0 = done_cnt[0];
        pulse_load(0, 12'h5A3);
        n = 0;
        do begin @(negedge clk); n++; end while (nbits[0] < 8 && n < 500);
        check("t4_reached_bit8", 32'(nbits[0] >= 8), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_rst_sclk", 32'(bus_a.SCLK), 1);
        check("t4_rst_sdi",  32'(bus_a.SDI),  0);
        check("t4_rst_csn",  32'(bus_a.CSn),  1);
        check("t4_rst_busy", 32'(bus_a.Busy), 0);
        check("t4_rst_done", 32'(bus_a.Done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t4_stays_idle", 32'(bus_a.CSn), 1);
        check("t4_no_frame", fcnt[0] - base, 0);
        check("t4_no_done", done_cnt[0] - d0, 0);
        pulse_load(0, 12'h3C6);
        wait_idle(0, "t4", n);
        check("t4_word", 32'(w_log[0][base]), 'h03C6);
        check("t4_csn_low", len_log[0][base], 68);
        check("t4_bits", nb_log[0][base], 16);
        check("t4_done", done_cnt[0] - d0, 1);

        // CLKDIV=1, CMD=0011: 34-cycle CSn low, Busy low in cycle 37.
        base_b = fcnt[1];
        pulse_load(1, 12'h800);
        wait_idle(1, "t5", n);
        check("t5_busy_cycles", n, 37);
        check("t5_word", 32'(w_log[1][base_b]), 'h3800);
        check("t5_csn_low", len_log[1][base_b], 34);
        check("t5_hi_max", hmax_log[1][base_b], 1);
        check("t5_lo_max", lmax_log[1][base_b], 1);

        // Load held high for 150 cycles with Din = 0x400 + cycle index:
        // captures at cycles 0, 70, 140, then the last pending word (0x495).
        base = fcnt[0]; d0 = done_cnt[0];
        @(posedge clk); #1;
        bus_a.Load = 1'b1;
        for (int k = 0; k < 150; k++) begin
            bus_a.Din = 12'(12'h400 + k);
            @(posedge clk); #1;
        end
        bus_a.Load = 1'b0;
        wait_idle(0, "t6", n);
        check("t6_frames", fcnt[0] - base, 4);
        check("t6_word0", 32'(w_log[0][base]),     'h0400);
        check("t6_word1", 32'(w_log[0][base + 1]), 'h0446);
        check("t6_word2", 32'(w_log[0][base + 2]), 'h048C);
        check("t6_word3", 32'(w_log[0][base + 3]), 'h0495);
        check("t6_gap1", g_log[0][base + 1], 2);
        check("t6_gap2", g_log[0][base + 2], 2);
        check("t6_gap3", g_log[0][base + 3], 2);
        check("t6_done", done_cnt[0] - d0, 4);

        check("sdi_zero_when_csn_high_a", sdi_bad[0], 0);
        check("sdi_zero_when_csn_high_b", sdi_bad[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
